// File: rtl/dds_pkg.sv
// Shared encodings for the DDS sweep core: FSM states, active-low waveform
// select codes and the encoded waveform identifiers.
package dds_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSweep = 2'd1,
    StDone  = 2'd2
  } dds_state_e;

  localparam logic [2:0] SEL_W0 = 3'b110;
  localparam logic [2:0] SEL_W1 = 3'b101;
  localparam logic [2:0] SEL_W2 = 3'b011;

  localparam logic [1:0] WAVE_ID0 = 2'd0;
  localparam logic [1:0] WAVE_ID1 = 2'd1;
  localparam logic [1:0] WAVE_ID2 = 2'd2;

endpackage

// File: rtl/dds_wave_sel_sync.sv
// Decodes the active-low one-hot waveform select and applies it to wave_id
// only at a phase zero-crossing (or immediately when the tone is stopped).
module dds_wave_sel_sync
  import dds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel_wave_i,
  input  logic       wrap_i,
  input  logic       fre_zero_i,
  output logic [1:0] wave_id_o
);

  logic [1:0] pend_q, pend_d;
  logic [1:0] wave_q, wave_d;

  always_comb begin
    pend_d = pend_q;
    case (sel_wave_i)
      SEL_W0:  pend_d = WAVE_ID0;
      SEL_W1:  pend_d = WAVE_ID1;
      SEL_W2:  pend_d = WAVE_ID2;
      default: pend_d = pend_q;
    endcase

    // A stopped accumulator never wraps, so switching must not wait for it.
    wave_d = wave_q;
    if (wrap_i || fre_zero_i) begin
      wave_d = pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= WAVE_ID0;
      wave_q <= WAVE_ID0;
    end else begin
      pend_q <= pend_d;
      wave_q <= wave_d;
    end
  end

  assign wave_id_o = wave_q;

endmodule

// File: rtl/dds_sweep_core.sv
// Phase-accumulator DDS with fixed-tone and linear frequency sweep modes,
// producing the ROM phase address and a wrap-aligned waveform select.
module dds_sweep_core
  import dds_pkg::*;
#(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ACC_W-1:0]   fre_k,
  input  logic [2:0]         sel_wave,
  input  logic [ACC_W-1:0]   fre_stop,
  input  logic [ACC_W-1:0]   fre_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               sweep_start,
  input  logic               sweep_abort,
  output logic [ADDR_W-1:0]  phase_addr,
  output logic [1:0]         wave_id,
  output logic [ACC_W-1:0]   cur_fre,
  output logic               sweep_busy,
  output logic               sweep_done
);

  dds_state_e         state_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   cur_fre_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic               degen_q;
  logic               busy_q;
  logic               done_q;
  logic               wrap;
  logic [ACC_W:0]     next_fre;

  assign {wrap, acc_d} = {1'b0, acc_q} + {1'b0, cur_fre_q};
  // One bit wider so a step past 2^ACC_W shows up as a large value, not a wrap.
  assign next_fre = {1'b0, cur_fre_q} + {1'b0, fre_step};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      addr_q <= '0;
    end else begin
      acc_q  <= acc_d;
      addr_q <= acc_q[ACC_W-1 -: ADDR_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cur_fre_q   <= '0;
      dwell_cnt_q <= '0;
      degen_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          cur_fre_q <= fre_k;
          if (sweep_start && !sweep_abort) begin
            state_q     <= StSweep;
            dwell_cnt_q <= dwell;
            degen_q     <= (fre_step == '0) || (fre_stop <= fre_k);
            busy_q      <= 1'b1;
          end
        end
        StSweep: begin
          if (sweep_abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (degen_q || (dwell_cnt_q == '0)) begin
            if (degen_q || (next_fre > {1'b0, fre_stop})) begin
              cur_fre_q <= fre_stop;
              state_q   <= StDone;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              cur_fre_q   <= next_fre[ACC_W-1:0];
              dwell_cnt_q <= dwell;
            end
          end else begin
            dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  dds_wave_sel_sync u_wave_sel_sync (
    .clk        (clk),
    .rst        (rst),
    .sel_wave_i (sel_wave),
    .wrap_i     (wrap),
    .fre_zero_i (cur_fre_q == '0),
    .wave_id_o  (wave_id)
  );

  assign phase_addr = addr_q;
  assign cur_fre    = cur_fre_q;
  assign sweep_busy = busy_q;
  assign sweep_done = done_q;

endmodule

// File: tb/tb_dds_sweep_core.sv
// Self-checking bench for dds_sweep_core: table-driven tone/wave vectors plus
// scoreboarded sweep sequences and hand-written abort/reset corner cases.
module tb_dds_sweep_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fre_k, fre_stop, fre_step;
  logic [2:0]  sel_wave;
  logic [15:0] dwell;
  logic        sweep_start, sweep_abort;
  logic [9:0]  phase_addr;
  logic [1:0]  wave_id;
  logic [31:0] cur_fre;
  logic        sweep_busy, sweep_done;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] fre_k;
    logic [2:0]  sel;
    logic [31:0] exp_cur;
    logic [1:0]  exp_wave;
  } vec_t;

  typedef struct {
    logic [31:0] cur;
    logic        busy;
    logic        done;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  always #5 clk = ~clk;

  dds_sweep_core u_dut (
    .clk         (clk),
    .rst         (rst),
    .fre_k       (fre_k),
    .sel_wave    (sel_wave),
    .fre_stop    (fre_stop),
    .fre_step    (fre_step),
    .dwell       (dwell),
    .sweep_start (sweep_start),
    .sweep_abort (sweep_abort),
    .phase_addr  (phase_addr),
    .wave_id     (wave_id),
    .cur_fre     (cur_fre),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_n(input logic [31:0] cur, input logic busy, input logic done,
                        input int n);
    exp_t e;
    e.cur  = cur;
    e.busy = busy;
    e.done = done;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // sweep_start must already be driven; fre_k changes after the start edge.
  task automatic drain(input logic [31:0] fre_after);
    exp_t e;
    bit   first;
    first = 1'b1;
    while (sb.size() > 0) begin
      tick();
      sweep_start = 1'b0;
      if (first) begin
        fre_k = fre_after;
        first = 1'b0;
      end
      e = sb.pop_front();
      check("sweep cur_fre", cur_fre, e.cur);
      check("sweep busy", 32'(sweep_busy), 32'(e.busy));
      check("sweep done", 32'(sweep_done), 32'(e.done));
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " phase_addr"}, 32'(phase_addr), 32'd0);
    check({name, " wave_id"}, 32'(wave_id), 32'd0);
    check({name, " cur_fre"}, cur_fre, 32'd0);
    check({name, " busy"}, 32'(sweep_busy), 32'd0);
    check({name, " done"}, 32'(sweep_done), 32'd0);
  endtask

  initial begin
    bit seen_done;

    vecs[0] = '{32'd0,          3'b101, 32'd0,          2'd1};
    vecs[1] = '{32'd0,          3'b011, 32'd0,          2'd2};
    vecs[2] = '{32'd0,          3'b100, 32'd0,          2'd2};
    vecs[3] = '{32'd0,          3'b111, 32'd0,          2'd2};
    vecs[4] = '{32'd0,          3'b110, 32'd0,          2'd0};
    vecs[5] = '{32'd0,          3'b000, 32'd0,          2'd0};
    vecs[6] = '{32'h1234_5678,  3'b101, 32'h1234_5678,  2'd1};
    vecs[7] = '{32'hFFFF_FFFF,  3'b101, 32'hFFFF_FFFF,  2'd1};
    vecs[8] = '{32'd1,          3'b101, 32'd1,          2'd1};
    vecs[9] = '{32'd0,          3'b101, 32'd0,          2'd1};

    rst = 1'b1; fre_k = '0; sel_wave = 3'b110; fre_stop = '0; fre_step = '0;
    dwell = '0; sweep_start = 1'b0; sweep_abort = 1'b0;
    tick();
    tick();
    check_all_zero("reset");

    // Fixed tone: quarter-scale tuning word gives a 4-clock address period.
    rst = 1'b0;
    fre_k = 32'h4000_0000;
    tick();
    check("tone cur_fre", cur_fre, 32'h4000_0000);
    for (int k = 2; k <= 9; k++) begin
      tick();
      check("tone phase_addr", 32'(phase_addr), 32'(((k - 2) % 4) * 256));
    end

    fre_k = 32'd0;
    tick();
    check("tone stop cur_fre", cur_fre, 32'd0);
    for (int i = 0; i < 10; i++) begin
      fre_k    = vecs[i].fre_k;
      sel_wave = vecs[i].sel;
      tick();
      check("vec cur_fre", cur_fre, vecs[i].exp_cur);
      check("vec wave_id", 32'(wave_id), 32'(vecs[i].exp_wave));
    end

    // Wrap-aligned switch: 1/16 scale wraps on the 17th edge after reset.
    rst = 1'b1; sel_wave = 3'b110; fre_k = 32'h1000_0000;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    sel_wave = 3'b101;
    for (int k = 4; k <= 20; k++) begin
      tick();
      check("wrap switch wave_id", 32'(wave_id), (k >= 17) ? 32'd1 : 32'd0);
    end
    sel_wave = 3'b100;
    for (int k = 21; k <= 40; k++) tick();
    check("invalid sel wave_id", 32'(wave_id), 32'd1);

    // Normal sweep; fre_k change during the sweep must be ignored.
    fre_k = 32'd100; fre_step = 32'd50; fre_stop = 32'd300; dwell = 16'd2;
    sweep_start = 1'b1;
    push_n(32'd100, 1'b1, 1'b0, 3);
    push_n(32'd150, 1'b1, 1'b0, 3);
    push_n(32'd200, 1'b1, 1'b0, 3);
    push_n(32'd250, 1'b1, 1'b0, 3);
    push_n(32'd300, 1'b1, 1'b0, 3);
    push_n(32'd300, 1'b0, 1'b1, 1);
    push_n(32'd300, 1'b0, 1'b0, 1);
    push_n(32'd777, 1'b0, 1'b0, 2);
    drain(32'd777);

    // Overshoot clamps to stop.
    fre_k = 32'd100; fre_step = 32'd150; fre_stop = 32'd300; dwell = 16'd2;
    sweep_start = 1'b1;
    push_n(32'd100, 1'b1, 1'b0, 3);
    push_n(32'd250, 1'b1, 1'b0, 3);
    push_n(32'd300, 1'b0, 1'b1, 1);
    push_n(32'd300, 1'b0, 1'b0, 1);
    push_n(32'd5, 1'b0, 1'b0, 1);
    drain(32'd5);

    // Carry out of the step must clamp rather than wrap to a small value.
    fre_k = 32'hFFFF_FF00; fre_step = 32'h200; fre_stop = 32'hFFFF_FFFF; dwell = 16'd0;
    sweep_start = 1'b1;
    push_n(32'hFFFF_FF00, 1'b1, 1'b0, 1);
    push_n(32'hFFFF_FFFF, 1'b0, 1'b1, 1);
    push_n(32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    push_n(32'd9, 1'b0, 1'b0, 1);
    drain(32'd9);

    // Degenerate: zero step.
    fre_k = 32'd100; fre_step = 32'd0; fre_stop = 32'd300; dwell = 16'd2;
    sweep_start = 1'b1;
    push_n(32'd100, 1'b1, 1'b0, 1);
    push_n(32'd300, 1'b0, 1'b1, 1);
    push_n(32'd300, 1'b0, 1'b0, 1);
    push_n(32'd11, 1'b0, 1'b0, 1);
    drain(32'd11);

    // Degenerate: stop below start.
    fre_k = 32'd500; fre_step = 32'd50; fre_stop = 32'd300; dwell = 16'd2;
    sweep_start = 1'b1;
    push_n(32'd500, 1'b1, 1'b0, 1);
    push_n(32'd300, 1'b0, 1'b1, 1);
    push_n(32'd300, 1'b0, 1'b0, 1);
    push_n(32'd13, 1'b0, 1'b0, 1);
    drain(32'd13);

    // Abort mid-sweep.
    fre_k = 32'd100; fre_step = 32'd50; fre_stop = 32'd300; dwell = 16'd2;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    check("abort pre busy", 32'(sweep_busy), 32'd1);
    tick();
    tick();
    tick();
    check("abort pre cur_fre", cur_fre, 32'd150);
    sweep_abort = 1'b1;
    tick();
    check("abort busy", 32'(sweep_busy), 32'd0);
    check("abort done", 32'(sweep_done), 32'd0);
    check("abort hold cur_fre", cur_fre, 32'd150);
    sweep_abort = 1'b0;
    seen_done = 1'b0;
    tick();
    check("abort reload cur_fre", cur_fre, 32'd100);
    for (int k = 0; k < 20; k++) begin
      if (sweep_done) seen_done = 1'b1;
      tick();
    end
    check("abort no done", 32'(seen_done), 32'd0);

    // Start and abort together: abort wins.
    fre_k = 32'd123;
    sweep_start = 1'b1;
    sweep_abort = 1'b1;
    tick();
    sweep_start = 1'b0;
    sweep_abort = 1'b0;
    check("start+abort busy", 32'(sweep_busy), 32'd0);
    check("start+abort cur_fre", cur_fre, 32'd123);
    tick();
    check("start+abort busy2", 32'(sweep_busy), 32'd0);
    check("start+abort done", 32'(sweep_done), 32'd0);

    // Reset during a sweep.
    fre_k = 32'd100; fre_step = 32'd50; fre_stop = 32'd300; dwell = 16'd2;
    sel_wave = 3'b101;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("mid-sweep reset");
    rst = 1'b0;
    tick();
    check("post reset busy", 32'(sweep_busy), 32'd0);
    check("post reset done", 32'(sweep_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
